int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt entry sequencer for the 5-stage pipeline. It latches an external interrupt request, freezes fetch, waits for in-flight instructions to drain, then injects stack writes (resume PC, optionally flags) into the memory stage. It then fetches the handler address from the vector location and redirects the PC. It sits beside the decode/ALU control path and drives the stall, memory-stage stack request and PC-load muxes; the ALU control itself is untouched.

## Interface
- `DRAIN_CYC`, default 3: cycles waited in DRAIN for older instructions to retire.
- `VEC_ADDR`, default 32'h0000_0000: data-memory address holding the 32-bit handler PC.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `int_req` in 1: interrupt request, level; sampled each cycle.
- `rti_done` in 1: one-cycle pulse from writeback when RTI retires.
- `pc_in` in 32: next-to-fetch PC from the fetch stage.
- `flags_in` in 3: CCR {C,N,Z}.
- `push_ack` in 1: memory stage accepted the current push.
- `rd_ack` in 1: vector read data is valid this cycle.
- `rd_data` in 32: vector read data.
- `stall_fetch` out 1: hold PC and the IF/ID register.
- `inject_nop` out 1: force a NOP into ID/EX.
- `push_req` out 1: stack push request.
- `push_data` out 16: word to push.
- `rd_req` out 1: vector read request.
- `rd_addr` out 32: equals `VEC_ADDR` whenever `rd_req` is high, 0 otherwise.
- `pc_load` out 1: one-cycle PC redirect strobe.
- `pc_load_val` out 32: handler PC.
- `in_service` out 1: handler active; further interrupts are held pending.

## Operation
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VEC_RD, JUMP.
- `pending` flag:
  - Set by `int_req`=1 in any cycle.
  - Cleared on the IDLE→DRAIN transition.
- IDLE→DRAIN when (`pending` | `int_req`) & !(`in_service` & !`rti_done`).
  - `in_service` is set on this transition.
- DRAIN:
  - Down-counter loads `DRAIN_CYC`-1 on entry.
  - Leaves for PUSH_HI when the counter is 0.
  - `pc_in` and `flags_in` are captured on the exit edge; a branch resolved during DRAIN therefore yields its target as the resume PC.
- PUSH_HI: `push_data`=pc[31:16]. PUSH_LO: `push_data`=pc[15:0]. PUSH_FLG: `push_data`={13'b0, flags}.
  - Each push state holds `push_req` high until `push_ack`=1, then advances on that edge.
  - `push_data` stays stable while `push_req` is high.
- VEC_RD: holds `rd_req` until `rd_ack`=1. `rd_data` is captured into `pc_load_val` on that edge, then the block goes to JUMP.
- JUMP: `pc_load`=1 for exactly one cycle, then IDLE.
- `stall_fetch` and `inject_nop` are high in every non-IDLE state.
- `in_service` is cleared by `rti_done` (in any state).
- `rti_done` and an accept condition in the same IDLE cycle: the clear takes effect first, so the new interrupt is accepted.
- `int_req` during a sequence or while `in_service`=1: only `pending` is set; the interrupt is taken after `rti_done`.
- Reset:
  - State=IDLE; `pending`, `in_service`, counter and captured PC/flags are cleared.
  - All outputs are 0, including `pc_load_val` and `push_data`.
  - Reset mid-sequence aborts immediately, with no further push or read strobes.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from `int_req` to any output.
- `int_req` sampled high at the end of cycle 0 in IDLE gives:
  - DRAIN in cycles 1..`DRAIN_CYC`.
  - PUSH_HI at `DRAIN_CYC`+1.
  - With zero-wait acks, one cycle each for the following states.
- `pc_load` cycle with zero-wait acks and `DRAIN_CYC`=3: cycle 8 with flags saving, cycle 7 without.
- Each wait cycle on `push_ack` or `rd_ack` adds exactly one cycle.
- Earliest re-entry: IDLE one cycle after JUMP, provided `in_service` has been cleared.

## Configuration
- `INT_SAVE_FLAGS_EN` defined:
  - PUSH_FLG is present (PUSH_LO→PUSH_FLG→VEC_RD).
  - `flags_in` is captured; three words are pushed.
- Not defined:
  - PUSH_LO→VEC_RD directly; two words are pushed.
  - `flags_in` is unused; the flags capture register and the PUSH_FLG decode are removed.

## Test plan
- Reset, then idle for 10 cycles: every output is 0.
- `INT_SAVE_FLAGS_EN` defined, `DRAIN_CYC`=3, `pc_in`=32'h0000_1234, flags=3'b101, acks tied high, `rd_data`=32'h0000_0200, `int_req` pulse at cycle 0:
  - Pushes 16'h0000, 16'h1234, 16'h0005 in cycles 4, 5, 6.
  - `rd_req` with `rd_addr`=0 in cycle 7.
  - `pc_load`=1 with `pc_load_val`=32'h200 in cycle 8.
  - `stall_fetch` high for cycles 1–8 only.
- `push_ack` held low for 3 cycles in PUSH_LO: `push_req` and `push_data`=16'h1234 are held stable, and `pc_load` slips by 3 cycles.
- Second `int_req` during the handler (`in_service`=1): no new sequence starts. `rti_done` pulse in cycle N gives DRAIN in cycle N+1.
- `rst` asserted in PUSH_LO: the next cycle is IDLE with all outputs 0, and no `rd_req` or `pc_load` follows.
- Macro undefined: the same stimulus as scenario 2 gives only two pushes, and `pc_load` in cycle 7.

Source files
------------

// File: rtl/int_sequencer.sv
// int_sequencer -- interrupt entry sequencer for the 5-stage pipeline.
//
// Latches an interrupt request, freezes fetch, lets in-flight instructions
// drain, pushes the resume PC (and optionally the CCR flags) through the
// memory stage, reads the handler address from VEC_ADDR and redirects the PC.
//
// Optional feature: define INT_SAVE_FLAGS_EN to push the {C,N,Z} flags as a
// third stack word (PUSH_LO -> PUSH_FLG -> VEC_RD). Without it only the two
// PC halves are pushed and flags_in is ignored.
//
// Parameters:
//   DRAIN_CYC   cycles spent in DRAIN (must be >= 1)
//   VEC_ADDR    data-memory address of the handler PC
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   int_req                level interrupt request
//   rti_done               pulse when RTI retires; ends in_service
//   pc_in, flags_in        resume PC and CCR from the pipeline
//   push_ack, rd_ack       memory-stage handshakes
//   rd_data                vector read data
//   stall_fetch/inject_nop pipeline freeze controls
//   push_req/push_data     stack push request and word
//   rd_req/rd_addr         vector read request and address
//   pc_load/pc_load_val    PC redirect strobe and handler PC
//   in_service             handler active
// All outputs are registered.
module int_sequencer #(
   parameter int          DRAIN_CYC = 3,
   parameter logic [31:0] VEC_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        int_req,
   input  logic        rti_done,
   input  logic [31:0] pc_in,
   input  logic [2:0]  flags_in,
   input  logic        push_ack,
   input  logic        rd_ack,
   input  logic [31:0] rd_data,
   output logic        stall_fetch,
   output logic        inject_nop,
   output logic        push_req,
   output logic [15:0] push_data,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   output logic        pc_load,
   output logic [31:0] pc_load_val,
   output logic        in_service
);

   localparam int CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VEC_RD, JUMP
   } stateT;

   stateT            state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [31:0]      pcCap, pcCapNext;
   logic [15:0]      pushDataNext;
   logic [31:0]      pcLoadValNext;
   logic             pending;
   logic             accept;
`ifdef INT_SAVE_FLAGS_EN
   logic [2:0]       flagsCap, flagsCapNext;
`else
   logic             unusedFlags;
   assign unusedFlags = ^flags_in;
`endif

   // Next-state decode; outputs are then registered from the next state so
   // they line up with the state they describe.
   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      pcCapNext     = pcCap;
`ifdef INT_SAVE_FLAGS_EN
      flagsCapNext  = flagsCap;
`endif
      // An rti_done in the same cycle releases in_service before the check.
      accept        = (state == IDLE) && (pending || int_req) &&
                      !(in_service && !rti_done);
      pcLoadValNext = pc_load_val;
      pushDataNext  = 16'h0000;

      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = DRAIN;
               cntNext   = CNT_LOAD;
            end
         end
         DRAIN: begin
            if (cnt == '0) begin
               stateNext = PUSH_HI;
               // Capture on the exit edge so a branch resolved while draining
               // supplies its target as the resume PC.
               pcCapNext = pc_in;
`ifdef INT_SAVE_FLAGS_EN
               flagsCapNext = flags_in;
`endif
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         PUSH_HI: if (push_ack) stateNext = PUSH_LO;
`ifdef INT_SAVE_FLAGS_EN
         PUSH_LO:  if (push_ack) stateNext = PUSH_FLG;
         PUSH_FLG: if (push_ack) stateNext = VEC_RD;
`else
         PUSH_LO:  if (push_ack) stateNext = VEC_RD;
`endif
         VEC_RD: begin
            if (rd_ack) begin
               stateNext     = JUMP;
               pcLoadValNext = rd_data;
            end
         end
         JUMP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      case (stateNext)
         PUSH_HI: pushDataNext = pcCapNext[31:16];
         PUSH_LO: pushDataNext = pcCapNext[15:0];
`ifdef INT_SAVE_FLAGS_EN
         PUSH_FLG: pushDataNext = {13'b0, flagsCapNext};
`endif
         default: pushDataNext = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         pcCap       <= '0;
`ifdef INT_SAVE_FLAGS_EN
         flagsCap    <= '0;
`endif
         pending     <= 1'b0;
         in_service  <= 1'b0;
         stall_fetch <= 1'b0;
         inject_nop  <= 1'b0;
         push_req    <= 1'b0;
         push_data   <= '0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         pc_load     <= 1'b0;
         pc_load_val <= '0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         pcCap       <= pcCapNext;
`ifdef INT_SAVE_FLAGS_EN
         flagsCap    <= flagsCapNext;
`endif
         // Acceptance consumes the request, even one arriving that same cycle.
         pending     <= accept ? 1'b0 : (pending | int_req);
         if (accept)
            in_service <= 1'b1;
         else if (rti_done)
            in_service <= 1'b0;
         stall_fetch <= (stateNext != IDLE);
         inject_nop  <= (stateNext != IDLE);
         push_req    <= (stateNext == PUSH_HI) || (stateNext == PUSH_LO) ||
                        (stateNext == PUSH_FLG);
         push_data   <= pushDataNext;
         rd_req      <= (stateNext == VEC_RD);
         rd_addr     <= (stateNext == VEC_RD) ? VEC_ADDR : 32'h0000_0000;
         pc_load     <= (stateNext == JUMP);
         pc_load_val <= pcLoadValNext;
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed testbench for int_sequencer. Works with or without
// INT_SAVE_FLAGS_EN; the expected push count follows the macro.
module tb_int_sequencer;

   localparam int          DRAIN = 3;
   localparam logic [31:0] VEC   = 32'h0000_0FF0;
`ifdef INT_SAVE_FLAGS_EN
   localparam int NPUSH = 3;
`else
   localparam int NPUSH = 2;
`endif

   logic        clk;
   logic        rst;
   logic        int_req;
   logic        rti_done;
   logic [31:0] pc_in;
   logic [2:0]  flags_in;
   logic        push_ack;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        stall_fetch;
   logic        inject_nop;
   logic        push_req;
   logic [15:0] push_data;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        pc_load;
   logic [31:0] pc_load_val;
   logic        in_service;

   int checks   = 0;
   int failures = 0;

   int_sequencer #(.DRAIN_CYC(DRAIN), .VEC_ADDR(VEC)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .rti_done(rti_done),
      .pc_in(pc_in), .flags_in(flags_in), .push_ack(push_ack),
      .rd_ack(rd_ack), .rd_data(rd_data), .stall_fetch(stall_fetch),
      .inject_nop(inject_nop), .push_req(push_req), .push_data(push_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .in_service(in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expectCycle(input string tag, input int cyc, input logic stall,
                              input logic pReq, input logic [15:0] pData,
                              input logic rReq, input logic pLoad,
                              input logic [31:0] pVal, input logic inSvc);
      check($sformatf("%s c%0d stall_fetch", tag, cyc), {31'b0, stall_fetch}, {31'b0, stall});
      check($sformatf("%s c%0d inject_nop", tag, cyc), {31'b0, inject_nop}, {31'b0, stall});
      check($sformatf("%s c%0d push_req", tag, cyc), {31'b0, push_req}, {31'b0, pReq});
      check($sformatf("%s c%0d push_data", tag, cyc), {16'b0, push_data}, {16'b0, pData});
      check($sformatf("%s c%0d rd_req", tag, cyc), {31'b0, rd_req}, {31'b0, rReq});
      check($sformatf("%s c%0d rd_addr", tag, cyc), rd_addr, rReq ? VEC : 32'h0);
      check($sformatf("%s c%0d pc_load", tag, cyc), {31'b0, pc_load}, {31'b0, pLoad});
      check($sformatf("%s c%0d pc_load_val", tag, cyc), pc_load_val, pVal);
      check($sformatf("%s c%0d in_service", tag, cyc), {31'b0, in_service}, {31'b0, inSvc});
   endtask

   // Called in cycle 1 (first DRAIN cycle). pc_in/flags_in are switched to
   // the resume values only in the last DRAIN cycle, so earlier values must
   // not leak into the pushes. loHold = push_ack low cycles in PUSH_LO.
   task automatic runSequence(input string tag, input logic [31:0] pcVal,
                              input logic [2:0] flg, input logic [31:0] vecData,
                              input logic [31:0] prevVal, input int loHold);
      logic [15:0] words [3];
      int cyc;
      words[0] = pcVal[31:16];
      words[1] = pcVal[15:0];
      words[2] = {13'b0, flg};
      cyc = 1;
      for (int c = 1; c <= DRAIN; c++) begin
         if (c == DRAIN) begin
            pc_in    = pcVal;
            flags_in = flg;
         end
         expectCycle({tag, " drain"}, cyc, 1, 0, 16'h0, 0, 0, prevVal, 1);
         step(); cyc++;
      end
      for (int p = 0; p < NPUSH; p++) begin
         if (p == 1) begin
            for (int h = 0; h < loHold; h++) begin
               push_ack = 1'b0;
               expectCycle({tag, " push_wait"}, cyc, 1, 1, words[1], 0, 0, prevVal, 1);
               step(); cyc++;
            end
         end
         push_ack = 1'b1;
         expectCycle({tag, " push"}, cyc, 1, 1, words[p], 0, 0, prevVal, 1);
         step(); cyc++;
      end
      expectCycle({tag, " vec_rd"}, cyc, 1, 0, 16'h0, 1, 0, prevVal, 1);
      step(); cyc++;
      expectCycle({tag, " jump"}, cyc, 1, 0, 16'h0, 0, 1, vecData, 1);
      step(); cyc++;
      expectCycle({tag, " after"}, cyc, 0, 0, 16'h0, 0, 0, vecData, 1);
   endtask

   initial begin
      rst = 1'b1; int_req = 1'b0; rti_done = 1'b0; pc_in = 32'h0;
      flags_in = 3'b000; push_ack = 1'b1; rd_ack = 1'b1; rd_data = 32'h0;

      // Reset state and 10 quiet idle cycles
      step(); step();
      expectCycle("reset", 0, 0, 0, 16'h0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step();
         expectCycle("idle", c, 0, 0, 16'h0, 0, 0, 32'h0, 0);
      end

      // Zero-wait sequence: pc 0x1234, flags 101, handler 0x200
      pc_in = 32'h0000_1234; flags_in = 3'b101; rd_data = 32'h0000_0200;
      int_req = 1'b1;                  // cycle 0
      step();
      int_req = 1'b0;
      runSequence("seq1", 32'h0000_1234, 3'b101, 32'h0000_0200, 32'h0, 0);

      // Request during the handler is held pending, not started
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         expectCycle("held", c, 0, 0, 16'h0, 0, 0, 32'h0000_0200, 1);
         step();
      end
      // rti_done in cycle N -> DRAIN in N+1; stale pc during DRAIN; PUSH_LO stalled 3 cycles
      pc_in = 32'h5555_AAAA; flags_in = 3'b111; rd_data = 32'h0000_0300;
      rti_done = 1'b1;
      expectCycle("rti", 0, 0, 0, 16'h0, 0, 0, 32'h0000_0200, 1);
      step();
      rti_done = 1'b0;
      runSequence("seq2", 32'h0000_1234, 3'b010, 32'h0000_0300, 32'h0000_0200, 3);

      // Clear in_service, then reset in the middle of PUSH_LO
      rti_done = 1'b1;
      step();
      rti_done = 1'b0;
      expectCycle("rti_clr", 0, 0, 0, 16'h0, 0, 0, 32'h0000_0300, 0);
      pc_in = 32'h0000_1234;
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      for (int c = 1; c <= DRAIN + 1; c++) begin
         expectCycle("abort_pre", c, 1, c > DRAIN, c > DRAIN ? 16'h0000 : 16'h0,
                     0, 0, 32'h0000_0300, 1);
         step();
      end
      expectCycle("abort_lo", DRAIN + 2, 1, 1, 16'h1234, 0, 0, 32'h0000_0300, 1);
      rst = 1'b1;
      step();
      expectCycle("abort_rst", DRAIN + 3, 0, 0, 16'h0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         expectCycle("abort_after", c, 0, 0, 16'h0, 0, 0, 32'h0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
